// File: rtl/game_master_fsm_multi.sv
// Master game controller: one torpedo, N_TARGETS target sprites.
// Tracks alive targets, score, lives and the win/lose outcome.
module game_master_fsm_multi #(
   parameter int N_TARGETS   = 4,
   parameter int SCORE_WIDTH = 8,
   parameter int LIVES       = 3,
   parameter int LIVES_WIDTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   launch_key,
   input  logic [N_TARGETS-1:0]   sprite_target_within_screen,
   input  logic                   sprite_torpedo_within_screen,
   input  logic [N_TARGETS-1:0]   collision,
   input  logic                   end_of_game_timer_running,
   output logic [N_TARGETS-1:0]   sprite_target_write_xy,
   output logic [N_TARGETS-1:0]   sprite_target_write_dxy,
   output logic [N_TARGETS-1:0]   sprite_target_enable_update,
   output logic                   sprite_torpedo_write_xy,
   output logic                   sprite_torpedo_write_dxy,
   output logic                   sprite_torpedo_enable_update,
   output logic                   end_of_game_timer_start,
   output logic                   game_won,
   output logic                   game_lost,
   output logic [SCORE_WIDTH-1:0] score,
   output logic [LIVES_WIDTH-1:0] lives_left
);

   typedef enum logic [2:0] {
      START,
      AIM,
      SHOOT,
      END_START,
      END_WAIT
   } state_t;

   state_t                 state, state_n;
   logic [N_TARGETS-1:0]   alive, alive_n;
   logic [SCORE_WIDTH-1:0] score_n;
   logic [LIVES_WIDTH-1:0] lives, lives_n;
   logic                   won, won_n;
   logic                   lost, lost_n;
   logic                   key_q;
   logic                   launch_edge;
   logic [N_TARGETS-1:0]   hits;
   logic [N_TARGETS-1:0]   respawn;
   logic [SCORE_WIDTH+4:0] score_sum;

   function automatic logic [4:0] popcount(input logic [N_TARGETS-1:0] v);
      logic [4:0] c;
      c = '0;
      for (int i = 0; i < N_TARGETS; i++) begin
         c = c + {4'd0, v[i]};
      end
      return c;
   endfunction

   assign launch_edge = launch_key & ~key_q;
   assign lives_left  = lives;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= START;
         alive <= '1;
         score <= '0;
         lives <= LIVES_WIDTH'(LIVES);
         won   <= 1'b0;
         lost  <= 1'b0;
         key_q <= 1'b0;
      end else begin
         state <= state_n;
         alive <= alive_n;
         score <= score_n;
         lives <= lives_n;
         won   <= won_n;
         lost  <= lost_n;
         key_q <= launch_key;
      end
   end

   always_comb begin
      state_n = state;
      alive_n = alive;
      score_n = score;
      lives_n = lives;
      won_n   = won;
      lost_n  = lost;
      sprite_target_write_xy       = '0;
      sprite_target_write_dxy      = '0;
      sprite_target_enable_update  = '0;
      sprite_torpedo_write_xy      = 1'b0;
      sprite_torpedo_write_dxy     = 1'b0;
      sprite_torpedo_enable_update = 1'b0;
      end_of_game_timer_start      = 1'b0;
      game_won  = 1'b0;
      game_lost = 1'b0;
      hits      = collision & alive;
      respawn   = alive & ~sprite_target_within_screen;
      score_sum = {5'd0, score} + {{SCORE_WIDTH{1'b0}}, popcount(hits)};

      unique case (state)
         START: begin
            sprite_target_write_xy   = '1;
            sprite_target_write_dxy  = '1;
            sprite_torpedo_write_xy  = 1'b1;
            sprite_torpedo_write_dxy = 1'b1;
            alive_n = '1;
            score_n = '0;
            lives_n = LIVES_WIDTH'(LIVES);
            won_n   = 1'b0;
            lost_n  = 1'b0;
            state_n = AIM;
         end
         AIM: begin
            sprite_target_enable_update = alive;
            sprite_target_write_xy      = respawn;
            sprite_target_write_dxy     = respawn;
            if (launch_edge) begin
               sprite_torpedo_write_dxy = 1'b1;
               state_n = SHOOT;
            end
         end
         SHOOT: begin
            sprite_target_enable_update  = alive;
            sprite_torpedo_enable_update = 1'b1;
            // a target hit while leaving the screen dies instead
            sprite_target_write_xy  = respawn & ~hits;
            sprite_target_write_dxy = respawn & ~hits;
            if (|hits) begin
               alive_n = alive & ~hits;
               if (score_sum > {5'd0, {SCORE_WIDTH{1'b1}}})
                  score_n = '1;
               else
                  score_n = score_sum[SCORE_WIDTH-1:0];
               if (alive_n == '0) begin
                  won_n   = 1'b1;
                  state_n = END_START;
               end else begin
                  sprite_torpedo_write_xy = 1'b1;
                  state_n = AIM;
               end
            end else if (!sprite_torpedo_within_screen) begin
               lives_n = lives - LIVES_WIDTH'(1);
               if (lives_n == '0) begin
                  lost_n  = 1'b1;
                  state_n = END_START;
               end else begin
                  sprite_torpedo_write_xy = 1'b1;
                  state_n = AIM;
               end
            end
         end
         END_START: begin
            end_of_game_timer_start = 1'b1;
            game_won  = won;
            game_lost = lost;
            state_n   = END_WAIT;
         end
         END_WAIT: begin
            game_won  = won;
            game_lost = lost;
            if (!end_of_game_timer_running)
               state_n = START;
         end
         default: state_n = START;
      endcase

      // reset lands in START, whose load strobes must stay quiet
      if (rst) begin
         sprite_target_write_xy       = '0;
         sprite_target_write_dxy      = '0;
         sprite_target_enable_update  = '0;
         sprite_torpedo_write_xy      = 1'b0;
         sprite_torpedo_write_dxy     = 1'b0;
         sprite_torpedo_enable_update = 1'b0;
         end_of_game_timer_start      = 1'b0;
         game_won  = 1'b0;
         game_lost = 1'b0;
      end
   end

endmodule

// File: tb/tb_game_master_fsm_multi.sv
// Scoreboard bench for game_master_fsm_multi: a game-level model
// predicts every cycle's outputs, a monitor compares them.
module tb_game_master_fsm_multi;

   localparam int N  = 4;
   localparam int SW = 2;
   localparam int LV = 3;
   localparam int LW = 2;
   localparam int BW = 3 * N + 6 + SW + LW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          launch_key = 1'b0;
   logic [N-1:0]  tgt_on = '1;
   logic          tor_on = 1'b1;
   logic [N-1:0]  collision = '0;
   logic          timer_running = 1'b0;
   logic [N-1:0]  t_wxy, t_wdxy, t_en;
   logic          p_wxy, p_wdxy, p_en, t_start, won, lost;
   logic [SW-1:0] score;
   logic [LW-1:0] lives_left;

   game_master_fsm_multi #(
      .N_TARGETS(N), .SCORE_WIDTH(SW), .LIVES(LV), .LIVES_WIDTH(LW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .launch_key(launch_key),
      .sprite_target_within_screen(tgt_on),
      .sprite_torpedo_within_screen(tor_on),
      .collision(collision),
      .end_of_game_timer_running(timer_running),
      .sprite_target_write_xy(t_wxy),
      .sprite_target_write_dxy(t_wdxy),
      .sprite_target_enable_update(t_en),
      .sprite_torpedo_write_xy(p_wxy),
      .sprite_torpedo_write_dxy(p_wdxy),
      .sprite_torpedo_enable_update(p_en),
      .end_of_game_timer_start(t_start),
      .game_won(won),
      .game_lost(lost),
      .score(score),
      .lives_left(lives_left)
   );

   always #5 clk = ~clk;

   logic [BW-1:0] exp_q[$];
   int errors = 0;
   int checks = 0;
   int steps  = 0;
   bit done   = 1'b0;

   // game phases of the model (not the RTL encoding)
   localparam int PH_SETUP  = 0;
   localparam int PH_READY  = 1;
   localparam int PH_FLYING = 2;
   localparam int PH_OVER   = 3;
   localparam int PH_WAIT   = 4;

   int           ph = PH_SETUP;
   logic [N-1:0] m_alive = '1;
   int           m_score = 0;
   int           m_lives = LV;
   bit           m_won = 0, m_lost = 0, m_pk = 0;

   task automatic step(input bit r, input bit k, input logic [N-1:0] tws,
                       input bit pws, input logic [N-1:0] col, input bit tr);
      logic [N-1:0] ewxy, ewdxy, een, hit, rsp;
      bit epwxy, epwdxy, epen, ets, ewon, elost;
      int sc_out, lv_out;
      @(negedge clk);
      rst = r; launch_key = k; tgt_on = tws;
      tor_on = pws; collision = col; timer_running = tr;
      ewxy = '0; ewdxy = '0; een = '0;
      epwxy = 0; epwdxy = 0; epen = 0; ets = 0; ewon = 0; elost = 0;
      if (r) begin
         sc_out = 0; lv_out = LV;
         ph = PH_SETUP; m_alive = '1; m_score = 0; m_lives = LV;
         m_won = 0; m_lost = 0; m_pk = 0;
      end else begin
         sc_out = m_score; lv_out = m_lives;
         rsp = m_alive & ~tws;
         hit = col & m_alive;
         if (ph == PH_SETUP) begin
            ewxy = '1; ewdxy = '1; epwxy = 1; epwdxy = 1;
            m_alive = '1; m_score = 0; m_lives = LV;
            m_won = 0; m_lost = 0; ph = PH_READY;
         end else if (ph == PH_READY) begin
            een = m_alive; ewxy = rsp; ewdxy = rsp;
            if (k && !m_pk) begin
               epwdxy = 1; ph = PH_FLYING;
            end
         end else if (ph == PH_FLYING) begin
            een = m_alive; epen = 1;
            ewxy = rsp & ~hit; ewdxy = rsp & ~hit;
            if (hit != 0) begin
               m_alive = m_alive & ~hit;
               m_score = m_score + $countones(hit);
               if (m_score > (1 << SW) - 1) m_score = (1 << SW) - 1;
               if (m_alive == 0) begin
                  m_won = 1; ph = PH_OVER;
               end else begin
                  epwxy = 1; ph = PH_READY;
               end
            end else if (!pws) begin
               m_lives = m_lives - 1;
               if (m_lives == 0) begin
                  m_lost = 1; ph = PH_OVER;
               end else begin
                  epwxy = 1; ph = PH_READY;
               end
            end
         end else if (ph == PH_OVER) begin
            ets = 1; ewon = m_won; elost = m_lost; ph = PH_WAIT;
         end else begin
            ewon = m_won; elost = m_lost;
            if (!tr) ph = PH_SETUP;
         end
         m_pk = k;
      end
      exp_q.push_back({ewxy, ewdxy, een, epwxy, epwdxy, epen, ets,
                       ewon, elost, SW'(sc_out), LW'(lv_out)});
   endtask

   task automatic idle(input int n, input bit k);
      for (int i = 0; i < n; i++) step(0, k, '1, 1, '0, 0);
   endtask

   task automatic fire();
      step(0, 0, '1, 1, '0, 0);
      step(0, 1, '1, 1, '0, 0);
   endtask

   task automatic shot(input logic [N-1:0] col, input bit pws);
      step(0, 1, '1, pws, col, 0);
   endtask

   // monitor: one output bundle per cycle
   initial begin : monitor
      logic [BW-1:0] act, want;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            act = {t_wxy, t_wdxy, t_en, p_wxy, p_wdxy, p_en, t_start,
                   won, lost, score, lives_left};
            checks++;
            if (act !== want) begin
               errors++;
               $display("FAIL outputs step=%0d got=%b want=%b (twxy,twdxy,ten,pwxy,pwdxy,pen,tstart,won,lost,score,lives)",
                        steps, act, want);
            end
            steps++;
         end
      end
   end

   initial begin : driver
      bit k;
      logic [N-1:0] tws, col;
      // key held through reset and into AIM must not fire
      repeat (3) step(1, 1, '1, 1, '0, 0);
      step(0, 1, '1, 1, '0, 0);
      idle(4, 1);
      fire();
      shot(4'b0110, 1);
      idle(2, 0);
      fire();
      shot(4'b0010, 1);
      shot(4'b0000, 0);
      fire();
      // last two targets, score saturates at 3
      shot(4'b1001, 0);
      repeat (100) step(0, 0, '1, 1, '0, 1);
      repeat (3) step(0, 0, '1, 1, '0, 0);
      for (int i = 0; i < 3; i++) begin
         fire();
         shot(4'b0000, 0);
      end
      repeat (3) step(0, 0, '1, 1, '0, 0);
      fire();
      shot(4'b0100, 0);
      step(0, 0, 4'b0111, 1, '0, 0);
      step(0, 0, 4'b1111, 1, '0, 0);
      fire();
      step(1, 1, '1, 1, '0, 0);
      step(1, 0, '1, 1, '0, 0);
      idle(3, 0);
      k = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) k = ~k;
         tws = '1;
         for (int b = 0; b < N; b++)
            if ($urandom_range(0, 15) == 0) tws[b] = 1'b0;
         col = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
         step($urandom_range(0, 499) == 0, k, tws,
              $urandom_range(0, 7) != 0, col,
              $urandom_range(0, 7) != 0);
      end
      repeat (2) @(negedge clk);
      #5;
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expected bundles never compared, want 0",
                  exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/game_master_fsm_multi.md
Name: game_master_fsm_multi

Overview:
- Master game controller for one torpedo and N_TARGETS independent target sprites.
- Replaces the single-target master FSM and adds per-target alive tracking, target respawn, a saturating score, a torpedo lives budget, and distinct win and lose outcomes.
- Drives the write, dxy and update strobes of every game_sprite_top instance.
- Consumes per-target overlap results, and starts and monitors the end-of-game timer consumed by the mixer.

Parameters:
N_TARGETS, 4, number of target sprites (1..16)
SCORE_WIDTH, 8, width of score counter
LIVES, 3, torpedoes available per game (1..2**LIVES_WIDTH-1)
LIVES_WIDTH, 2, width of lives counter

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
launch_key  input  1  fire request, level, edge-detected internally
sprite_target_within_screen  input  N_TARGETS  per-target on-screen flag
sprite_torpedo_within_screen  input  1  torpedo on-screen flag
collision  input  N_TARGETS  per-target overlap with torpedo
end_of_game_timer_running  input  1  end-of-game timer busy
sprite_target_write_xy  output  N_TARGETS  load position strobe per target
sprite_target_write_dxy  output  N_TARGETS  load velocity strobe per target
sprite_target_enable_update  output  N_TARGETS  motion enable per target
sprite_torpedo_write_xy  output  1  load torpedo position
sprite_torpedo_write_dxy  output  1  load torpedo velocity
sprite_torpedo_enable_update  output  1  torpedo motion enable
end_of_game_timer_start  output  1  one-cycle timer start pulse
game_won  output  1  high in END after a win
game_lost  output  1  high in END after a loss
score  output  SCORE_WIDTH  targets destroyed this game
lives_left  output  LIVES_WIDTH  torpedoes remaining

Behaviour:
- States: START, AIM, SHOOT, END_START, END_WAIT. Encoding is enumerated.
- Registers: state, alive[N_TARGETS], score, lives, won, lost, key_q.
- While rst is high: state=START, alive=all 1, score=0, lives=LIVES, won=lost=0, key_q=0. All strobe outputs are forced 0.
- Reset mid-operation returns immediately to these values.
- Strobes are combinational decodes of the current state and inputs. Counter and register updates take effect at the next clk edge.
- launch_edge = launch_key & ~key_q. key_q samples launch_key every cycle.
- START (one cycle):
  - Assert all target write_xy and write_dxy, plus torpedo write_xy and write_dxy.
  - Load alive=all 1, score=0, lives=LIVES, won=lost=0.
  - Go to AIM.
- AIM:
  - target_enable_update = alive. Torpedo is parked with enable_update=0.
  - On launch_edge: assert torpedo write_dxy that cycle and go to SHOOT.
- SHOOT:
  - target_enable_update = alive. torpedo_enable_update=1.
  - hits = collision & alive.
- SHOOT, hits nonzero (highest priority):
  - Clear those alive bits.
  - Increment score by popcount(hits), saturating at 2**SCORE_WIDTH-1.
  - If the new alive is zero: set won and go to END_START.
  - Otherwise: assert torpedo write_xy and go to AIM.
- SHOOT, no hits and torpedo_within_screen=0:
  - Decrement lives.
  - If the new lives=0: set lost and go to END_START.
  - Otherwise: assert torpedo write_xy and go to AIM.
- Target respawn (AIM or SHOOT, independent of the above):
  - Any alive target i with within_screen[i]=0 gets write_xy[i] and write_dxy[i] asserted in the same cycle.
  - A target hit in the same cycle it leaves the screen is killed, not respawned.
- Dead targets have all three strobes held at 0 and are ignored for collision.
- END_START (one cycle): end_of_game_timer_start=1. All enable_update=0. Go to END_WAIT.
- END_WAIT:
  - Hold all motion disabled.
  - When end_of_game_timer_running=0, go to START. The timer's running flag is valid the cycle after start.
  - game_won=won and game_lost=lost are driven in END_START and END_WAIT only, 0 elsewhere.
- launch_key held across START, or across the return to AIM, does not fire. A new rising edge is required.
- score and lives_left are direct register outputs.

Test Plan:
- Reset release, N_TARGETS=4 → first cycle: target_write_xy=4'b1111, torpedo_write_xy=1. Next cycle AIM with target_enable_update=4'b1111, torpedo_enable_update=0, score=0, lives_left=3.
- launch_key held high through reset and AIM → no SHOOT entry. Drop then raise → SHOOT next cycle, torpedo_write_dxy pulsed exactly once.
- In SHOOT, collision=4'b0110 in one cycle → score=2, target_enable_update=4'b1001, torpedo_write_xy pulse, back to AIM. Repeat collision=4'b0010 (dead target) → no score change.
- Kill all four targets → game_won=1 and end_of_game_timer_start pulses once. Hold timer_running=1 for 100 cycles → stays in END_WAIT. Drop it → START, score reset to 0.
- Three misses (torpedo_within_screen=0, no collision) → lives_left 3→2→1. Third miss → game_lost=1, game_won=0. Same-cycle collision plus off-screen counts as a hit, lives unchanged.
- Alive target 3 leaves the screen in AIM → target_write_xy=4'b1000 and target_write_dxy=4'b1000 for one cycle. Assert rst mid-SHOOT → outputs zero immediately, START after release.
